imem_stim_sequencer: RTL and testbench
======================================

Name: imem_stim_sequencer

Overview:
- Synthesizable, parametrised stimulus and check engine for the PMIPS core family; replaces hand-timed instruction driving.
- Holds a loadable table of instruction words, each with a hold count.
- Drives the core's instruction-read bus and core reset, then compares the core's register-file snapshot against expected values and reports pass/fail.
- Sits between a host or loader and the core; runs in simulation and on the Spartan-3E board.

Parameters:
- DATA_W, 16, instruction and register word width
- DEPTH, 16, instruction table entries
- HOLD_W, 4, hold-count field width; entry is driven hold+1 cycles
- NREG, 8, number of core registers checked
- RESET_CYCLES, 1, cycles cpu_reset stays high after start

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high block reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- load_en  in  1  write one table entry
- load_addr  in  clog2(DEPTH)  table entry index
- load_instr  in  DATA_W  instruction word
- load_hold  in  HOLD_W  hold count
- load_last  in  1  marks the entry as final in the program
- exp_we  in  1  write one expected register value
- exp_idx  in  clog2(NREG)  expected-value index
- exp_val  in  DATA_W  expected value
- reg_flat  in  NREG*DATA_W  core register snapshot; reg i is at bits [i*DATA_W +: DATA_W]
- imemrdata  out  DATA_W  instruction driven to the core
- cpu_reset  out  1  core reset
- entry_idx  out  clog2(DEPTH)  table entry currently driven
- busy  out  1  high in RST, RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  valid while done is high
- fail_idx  out  clog2(NREG)  first mismatching register; 0 when pass

Behaviour:
- States: IDLE, RST, RUN, CHECK, DONE.
- Reset values: state IDLE, imemrdata 0 (NOP), cpu_reset 1, entry_idx 0, busy 0, done 0, pass 0, fail_idx 0. Table and expected storage are not cleared by reset.
- IDLE:
  - imemrdata is 0 and cpu_reset is 1.
  - start moves to RST on the next edge.
- RST:
  - cpu_reset stays 1 for RESET_CYCLES cycles; imemrdata shows entry 0.
  - Then moves to RUN with cpu_reset 0.
- RUN:
  - imemrdata = instr[entry_idx], registered, and is held for hold[entry_idx]+1 cycles.
  - Then entry_idx increments.
  - After the entry marked last, or after entry DEPTH-1 if none is marked last, moves to CHECK. Entries never wrap.
- CHECK:
  - Compares one register per cycle, index 0..NREG-1, using the registered reg_flat slice.
  - fail_idx latches the first mismatch.
  - imemrdata returns to 0 and cpu_reset stays 0, so the core stays live.
  - After NREG cycles, moves to DONE.
- DONE:
  - done=1; pass=1 if no mismatch was found.
  - Holds until the next start, which restarts the run at RST.
- Total cycles from the start edge to done: RESET_CYCLES + sum over entries of (hold+1) + NREG + 1.
- start while busy: ignored.
- load_en or exp_we while busy: ignored. Storage is writable only in IDLE and DONE.
- load_en together with start in IDLE or DONE: the load completes, start is ignored that cycle.
- Out-of-range load_addr or exp_idx (non power-of-2 sizes): write dropped.
- reset mid-run: state returns to IDLE next edge; cpu_reset 1; status cleared.

Optional Feature:
- EXP_MASK_EN defined:
  - A per-register valid bit is set by exp_we.
  - Registers whose valid bit is clear are skipped and counted as matching.
  - All valid bits clear on reset.
- EXP_MASK_EN undefined:
  - All NREG registers are compared.
  - A never-written expected value compares against whatever the storage holds; the bench must write all of them.

Decomposition:
- Package pmips_tb_pkg: state enumeration and the NOP_WORD constant (0).
- Sub-module stim_table: DEPTH x (DATA_W + HOLD_W + 1) storage with write port and registered read port.
- The FSM, compare logic and expected storage stay in the top module.

Test Plan:
- Basic pass run:
  - Load 0x6083/h3, 0x6104/h3, 0x08C3/h3, 0x407E/h3 (last); expected R1=3, R2=4, R4=7, others 0; bench drives a matching reg_flat; start.
  - imemrdata shows each word for 4 cycles; done after 1+16+8+1=26 cycles; pass=1.
- Single mismatch: same program with reg_flat R4=6 -> pass=0, fail_idx=4.
- Multiple mismatches: R2 and R5 wrong -> fail_idx=2 (first mismatch only).
- No last flag, DEPTH=4, all holds 0 -> RUN lasts 4 cycles; entry_idx reaches 3 and does not wrap; cpu_reset is 1 only during the RST cycle.
- reset asserted during RUN at entry 2 -> next cycle IDLE, cpu_reset=1, imemrdata=0, busy=0; a later start reruns the stored program unchanged.
- Protocol corner cases:
  - start pulsed while busy: no effect.
  - load_en while busy: table unchanged.
  - With EXP_MASK_EN, expected written only for R1: a mismatch on R3 still gives pass=1.

Source files
------------

// File: rtl/pmips_tb_pkg.sv
// Shared types for the PMIPS stimulus/check sequencer.
package pmips_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_CHECK,
    S_DONE
  } seq_state_t;

  localparam int unsigned NOP_WORD = 0;

endpackage

// File: rtl/stim_table.sv
// Instruction table: DEPTH entries of {instr, hold, last}.
// The read port is registered and its instruction output feeds the core directly.
module stim_table
  import pmips_tb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 4,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_instr,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic              wr_last,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rd_instr,
  output logic [HOLD_W-1:0] rd_hold,
  output logic              rd_last
);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem  [DEPTH];
  logic              last_mem  [DEPTH];

  // Host write port; range checking is done by the caller.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      instr_mem[wr_addr] <= wr_instr;
      hold_mem[wr_addr]  <= wr_hold;
      last_mem[wr_addr]  <= wr_last;
    end
  end

  // Registered read; clear forces a NOP onto the instruction bus.
  always_ff @(posedge clock) begin
    if (rd_clr) begin
      rd_instr <= DATA_W'(NOP_WORD);
      rd_hold  <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_instr <= instr_mem[rd_addr];
      rd_hold  <= hold_mem[rd_addr];
      rd_last  <= last_mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_stim_sequencer.sv
// PMIPS stimulus and check engine: drives a loaded instruction program onto
// the core's instruction bus, then compares the register snapshot.
// Optional build macro EXP_MASK_EN: per-register valid bits, unwritten
// expected values are skipped during the check.
module imem_stim_sequencer
  import pmips_tb_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int HOLD_W       = 4,
  parameter int NREG         = 8,
  parameter int RESET_CYCLES = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_addr,
  input  logic [DATA_W-1:0]      load_instr,
  input  logic [HOLD_W-1:0]      load_hold,
  input  logic                   load_last,
  input  logic                   exp_we,
  input  logic [IW-1:0]          exp_idx,
  input  logic [DATA_W-1:0]      exp_val,
  input  logic [NREG*DATA_W-1:0] reg_flat,
  output logic [DATA_W-1:0]      imemrdata,
  output logic                   cpu_reset,
  output logic [AW-1:0]          entry_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [IW-1:0]          fail_idx
);

  localparam int CW = $clog2(NREG + 1);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  seq_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RW-1:0]     rst_cnt;
  logic [CW-1:0]     chk_cnt;
  logic [DATA_W-1:0] reg_q;
  logic [IW-1:0]     cmp_idx_q;
  logic              cmp_vld_q;
  logic              fail_seen;
  logic [DATA_W-1:0] exp_mem [NREG];

  logic [HOLD_W-1:0] tbl_hold;
  logic              tbl_last;
  logic [AW-1:0]     rd_addr;
  logic              rd_clr;
  logic              store_open, start_ok, tbl_wr, exp_wr;
  logic              hold_done, at_end, mismatch_now;

  assign store_open = (state == S_IDLE) || (state == S_DONE);
  assign start_ok   = start && !load_en && store_open;
  assign tbl_wr     = load_en && store_open && (32'(load_addr) < 32'(DEPTH));
  assign exp_wr     = exp_we && store_open && (32'(exp_idx) < 32'(NREG));
  assign hold_done  = (hold_cnt == tbl_hold);
  assign at_end     = tbl_last || (entry_idx == AW'(DEPTH - 1));

  stim_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W),
    .AW     (AW)
  ) u_table (
    .clock    (clock),
    .wr_en    (tbl_wr),
    .wr_addr  (load_addr),
    .wr_instr (load_instr),
    .wr_hold  (load_hold),
    .wr_last  (load_last),
    .rd_addr  (rd_addr),
    .rd_clr   (rd_clr),
    .rd_instr (imemrdata),
    .rd_hold  (tbl_hold),
    .rd_last  (tbl_last)
  );

  // Read-address lookahead: the table's output register must already hold
  // the entry the FSM moves to, so the address follows the FSM's next step.
  always_comb begin
    rd_addr = entry_idx;
    rd_clr  = 1'b1;
    if (!reset) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            rd_addr = '0;
            rd_clr  = 1'b0;
          end
        end
        S_RST: begin
          rd_addr = '0;
          rd_clr  = 1'b0;
        end
        S_RUN: begin
          if (!(hold_done && at_end)) begin
            rd_addr = hold_done ? entry_idx + AW'(1) : entry_idx;
            rd_clr  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Expected-value storage, writable only while idle or done.
  always_ff @(posedge clock) begin
    if (exp_wr) exp_mem[exp_idx] <= exp_val;
  end

`ifdef EXP_MASK_EN
  logic [NREG-1:0] exp_vld;

  // Valid bit per expected register; cleared by block reset.
  always_ff @(posedge clock) begin
    if (reset)       exp_vld <= '0;
    else if (exp_wr) exp_vld[exp_idx] <= 1'b1;
  end

  // Compare the registered snapshot slice; unwritten registers always match.
  always_comb begin
    mismatch_now = cmp_vld_q && exp_vld[cmp_idx_q] && (reg_q != exp_mem[cmp_idx_q]);
  end
`else
  // Compare the registered snapshot slice against its expected value.
  always_comb begin
    mismatch_now = cmp_vld_q && (reg_q != exp_mem[cmp_idx_q]);
  end
`endif

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cpu_reset <= 1'b1;
      entry_idx <= '0;
      hold_cnt  <= '0;
      rst_cnt   <= '0;
      chk_cnt   <= '0;
      reg_q     <= '0;
      cmp_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      fail_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
    end else begin
      cmp_vld_q <= 1'b0;
      if (mismatch_now && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_idx  <= cmp_idx_q;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state     <= S_RST;
            cpu_reset <= 1'b1;
            entry_idx <= '0;
            rst_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            fail_seen <= 1'b0;
          end
        end
        S_RST: begin
          if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            hold_cnt  <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_RUN: begin
          if (hold_done) begin
            hold_cnt <= '0;
            if (at_end) begin
              state   <= S_CHECK;
              chk_cnt <= '0;
            end else begin
              entry_idx <= entry_idx + AW'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_CHECK: begin
          // One extra cycle drains the compare of the last captured slice.
          if (chk_cnt < CW'(NREG)) begin
            reg_q     <= reg_flat[int'(chk_cnt)*DATA_W +: DATA_W];
            cmp_idx_q <= chk_cnt[IW-1:0];
            cmp_vld_q <= 1'b1;
            chk_cnt   <= chk_cnt + CW'(1);
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(fail_seen || mismatch_now);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stim_sequencer.sv
// Self-checking bench for imem_stim_sequencer against a cycle-trace model
// built from the program table. Honors EXP_MASK_EN when defined.
module tb_imem_stim_sequencer;

  localparam int DATA_W       = 16;
  localparam int DEPTH        = 4;
  localparam int HOLD_W       = 4;
  localparam int NREG         = 8;
  localparam int RESET_CYCLES = 1;
  localparam int AW           = $clog2(DEPTH);
  localparam int IW           = $clog2(NREG);
  localparam int LIMIT        = 300;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   load_en = 1'b0;
  logic [AW-1:0]          load_addr = '0;
  logic [DATA_W-1:0]      load_instr = '0;
  logic [HOLD_W-1:0]      load_hold = '0;
  logic                   load_last = 1'b0;
  logic                   exp_we = 1'b0;
  logic [IW-1:0]          exp_idx = '0;
  logic [DATA_W-1:0]      exp_val = '0;
  logic [NREG*DATA_W-1:0] reg_flat = '0;
  logic [DATA_W-1:0]      imemrdata;
  logic                   cpu_reset;
  logic [AW-1:0]          entry_idx;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [IW-1:0]          fail_idx;

  imem_stim_sequencer #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .HOLD_W       (HOLD_W),
    .NREG         (NREG),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_instr (load_instr),
    .load_hold  (load_hold),
    .load_last  (load_last),
    .exp_we     (exp_we),
    .exp_idx    (exp_idx),
    .exp_val    (exp_val),
    .reg_flat   (reg_flat),
    .imemrdata  (imemrdata),
    .cpu_reset  (cpu_reset),
    .entry_idx  (entry_idx),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_idx   (fail_idx)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_instr [DEPTH];
  int                m_hold  [DEPTH];
  bit                m_last  [DEPTH];
  logic [DATA_W-1:0] m_exp   [NREG];
  bit                m_vld   [NREG];
  logic [DATA_W-1:0] regs    [NREG];

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic              crst;
    logic [AW-1:0]     entry;
    logic              busy;
    logic              done;
  } obs_t;

  obs_t exp_q[$];

  function automatic int prog_len();
    for (int e = 0; e < DEPTH; e++) if (m_last[e]) return e + 1;
    return DEPTH;
  endfunction

  function automatic int model_cycles();
    int s = 0;
    for (int e = 0; e < prog_len(); e++) s += m_hold[e] + 1;
    return RESET_CYCLES + s + NREG + 1;
  endfunction

  function automatic int model_fail();
    for (int i = 0; i < NREG; i++) if (m_vld[i] && regs[i] !== m_exp[i]) return i;
    return -1;
  endfunction

  // Expected observation for every cycle from the start edge to done.
  function automatic void build_trace();
    int   len = prog_len();
    obs_t o;
    exp_q.delete();
    for (int r = 0; r < RESET_CYCLES; r++) begin
      o = '{instr: m_instr[0], crst: 1'b1, entry: '0, busy: 1'b1, done: 1'b0};
      exp_q.push_back(o);
    end
    for (int e = 0; e < len; e++)
      for (int h = 0; h <= m_hold[e]; h++) begin
        o = '{instr: m_instr[e], crst: 1'b0, entry: AW'(e), busy: 1'b1, done: 1'b0};
        exp_q.push_back(o);
      end
    for (int c = 0; c <= NREG; c++) begin
      o = '{instr: '0, crst: 1'b0, entry: AW'(len - 1), busy: 1'b1, done: 1'b0};
      exp_q.push_back(o);
    end
    o = '{instr: '0, crst: 1'b0, entry: AW'(len - 1), busy: 1'b0, done: 1'b1};
    exp_q.push_back(o);
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o = '{instr: imemrdata, crst: cpu_reset, entry: entry_idx, busy: busy, done: done};
    return o;
  endfunction

  task automatic load_entry(input int a, input logic [DATA_W-1:0] ins, input int h, input bit last);
    @(negedge clock);
    load_en = 1'b1; load_addr = AW'(a); load_instr = ins; load_hold = HOLD_W'(h); load_last = last;
    m_instr[a] = ins; m_hold[a] = h; m_last[a] = last;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic write_exp(input int i, input logic [DATA_W-1:0] v);
    @(negedge clock);
    exp_we = 1'b1; exp_idx = IW'(i); exp_val = v;
    m_exp[i] = v; m_vld[i] = 1'b1;
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  task automatic apply_regs();
    for (int i = 0; i < NREG; i++) reg_flat[i*DATA_W +: DATA_W] = regs[i];
  endtask

  task automatic clear_mask_model();
`ifdef EXP_MASK_EN
    for (int i = 0; i < NREG; i++) m_vld[i] = 1'b0;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(posedge clock);
      #1 cyc++;
    end
  endtask

  task automatic load_basic_program();
    load_entry(0, 16'h6083, 3, 1'b0);
    load_entry(1, 16'h6104, 3, 1'b0);
    load_entry(2, 16'h08C3, 3, 1'b0);
    load_entry(3, 16'h407E, 3, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (imemrdata !== '0 || cpu_reset !== 1'b1 || entry_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: imem=%h cpu_reset=%b entry=%0d, need 0/1/0", imemrdata, cpu_reset, entry_idx);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b pass=%b fail_idx=%0d, need all 0", busy, done, pass, fail_idx);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (imemrdata !== '0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: imem=%h cpu_reset=%b busy=%b, need 0/1/0", imemrdata, cpu_reset, busy);
    end
  endtask

  task automatic test_basic_pass();
    obs_t o;
    load_basic_program();
    for (int i = 0; i < NREG; i++) write_exp(i, '0);
    write_exp(1, 16'd3);
    write_exp(2, 16'd4);
    write_exp(4, 16'd7);
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    apply_regs();
    build_trace();
    pulse_start();
    foreach (exp_q[k]) begin
      if (k > 0) begin @(posedge clock); #1; end
      o = get_obs();
      n_checks++;
      if (o !== exp_q[k]) begin
        n_fail++;
        $display("FAIL basic_trace cycle %0d: got %h expected %h", k, o, exp_q[k]);
      end
    end
    n_checks++;
    if (pass !== 1'b1 || fail_idx !== '0) begin
      n_fail++;
      $display("FAIL basic_result: pass=%b fail_idx=%0d, need 1/0", pass, fail_idx);
    end
  endtask

  task automatic test_single_mismatch();
    int cyc;
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    regs[4] = 16'd6;
    apply_regs();
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (cyc != 26) begin
      n_fail++;
      $display("FAIL single_cycles: got %0d need 26", cyc);
    end
    n_checks++;
    if (pass !== 1'b0 || fail_idx !== IW'(4)) begin
      n_fail++;
      $display("FAIL single_result: pass=%b fail_idx=%0d, need 0/4", pass, fail_idx);
    end
  endtask

  task automatic test_multi_mismatch();
    int cyc;
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    regs[2] = 16'd5;
    regs[5] = 16'h0055;
    apply_regs();
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (cyc != model_cycles() || pass !== 1'b0 || fail_idx !== IW'(2)) begin
      n_fail++;
      $display("FAIL multi_result: cycles=%0d pass=%b fail_idx=%0d, need %0d/0/2", cyc, pass, fail_idx, model_cycles());
    end
  endtask

  task automatic test_start_while_busy();
    int cyc = 0;
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    apply_regs();
    pulse_start();
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clock);
      start = (cyc == 2 || cyc == 19);
      @(posedge clock);
      #1 start = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc != model_cycles() || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: cycles=%0d pass=%b, need %0d/1", cyc, pass, model_cycles());
    end
    repeat (3) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
        n_fail++;
        $display("FAIL done_hold: done=%b busy=%b pass=%b, need 1/0/1", done, busy, pass);
      end
    end
  endtask

  task automatic test_load_while_busy();
    int cyc = 0;
    pulse_start();
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clock);
      load_en = (cyc == 4); load_addr = '0; load_instr = 16'hDEAD;
      load_hold = HOLD_W'(7); load_last = 1'b1;
      exp_we = (cyc == 6); exp_idx = IW'(1); exp_val = 16'hBEEF;
      @(posedge clock);
      #1;
      load_en = 1'b0; exp_we = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc != model_cycles() || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL load_busy_run1: cycles=%0d pass=%b, need %0d/1", cyc, pass, model_cycles());
    end
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (cyc != model_cycles() || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL load_busy_run2: cycles=%0d pass=%b, need %0d/1", cyc, pass, model_cycles());
    end
  endtask

  task automatic test_load_with_start();
    int cyc;
    @(negedge clock);
    load_en = 1'b1; load_addr = AW'(1); load_instr = m_instr[1];
    load_hold = '0; load_last = 1'b0; start = 1'b1;
    m_hold[1] = 0;
    @(posedge clock);
    #1;
    load_en = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL load_start_ignored: busy=%b done=%b, need 0/1", busy, done);
    end
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (cyc != model_cycles() || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL load_start_rerun: cycles=%0d pass=%b, need %0d/1", cyc, pass, model_cycles());
    end
  endtask

  task automatic test_no_last();
    obs_t o;
    for (int e = 0; e < DEPTH; e++) load_entry(e, DATA_W'($urandom), 0, 1'b0);
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    apply_regs();
    build_trace();
    pulse_start();
    foreach (exp_q[k]) begin
      if (k > 0) begin @(posedge clock); #1; end
      o = get_obs();
      n_checks++;
      if (o !== exp_q[k]) begin
        n_fail++;
        $display("FAIL nolast_trace cycle %0d: got %h expected %h", k, o, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc = 0;
    load_basic_program();
    for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
    apply_regs();
    pulse_start();
    while (!(int'(entry_idx) == 2 && cpu_reset === 1'b0) && cyc < LIMIT) begin
      @(posedge clock);
      #1 cyc++;
    end
    n_checks++;
    if (cyc >= LIMIT) begin
      n_fail++;
      $display("FAIL midrun_reach: entry 2 not reached in %0d cycles", cyc);
    end
    @(negedge clock);
    reset = 1'b1;
    clear_mask_model();
    @(posedge clock);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || imemrdata !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || fail_idx !== '0 || entry_idx !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: cpu_reset=%b imem=%h busy=%b done=%b pass=%b fail_idx=%0d entry=%0d",
               cpu_reset, imemrdata, busy, done, pass, fail_idx, entry_idx);
    end
    @(negedge clock);
    reset = 1'b0;
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (cyc != 26 || pass !== (model_fail() < 0)) begin
      n_fail++;
      $display("FAIL midrun_rerun: cycles=%0d pass=%b, need 26/%0b", cyc, pass, model_fail() < 0);
    end
  endtask

  task automatic test_mask();
`ifdef EXP_MASK_EN
    int cyc;
    @(negedge clock);
    reset = 1'b1;
    clear_mask_model();
    @(negedge clock);
    reset = 1'b0;
    write_exp(1, 16'd3);
    for (int i = 0; i < NREG; i++) regs[i] = DATA_W'($urandom);
    regs[1] = 16'd3;
    regs[3] = m_exp[3] ^ 16'h0001;
    apply_regs();
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (pass !== 1'b1 || fail_idx !== '0) begin
      n_fail++;
      $display("FAIL mask_skip: pass=%b fail_idx=%0d, need 1/0", pass, fail_idx);
    end
    regs[1] = 16'd4;
    apply_regs();
    pulse_start();
    wait_done(cyc);
    n_checks++;
    if (pass !== 1'b0 || fail_idx !== IW'(1)) begin
      n_fail++;
      $display("FAIL mask_valid: pass=%b fail_idx=%0d, need 0/1", pass, fail_idx);
    end
`endif
  endtask

  task automatic test_random_programs();
    obs_t o;
    int   lastpos, mode, mf, r;
    repeat (6) begin
      lastpos = $urandom_range(0, DEPTH);
      for (int e = 0; e < DEPTH; e++)
        load_entry(e, DATA_W'($urandom), $urandom_range(0, 3), (e == lastpos));
      for (int i = 0; i < NREG; i++) write_exp(i, DATA_W'($urandom));
      for (int i = 0; i < NREG; i++) regs[i] = m_exp[i];
      mode = $urandom_range(0, 2);
      for (int m = 0; m < mode; m++) begin
        r = $urandom_range(0, NREG - 1);
        regs[r] = regs[r] ^ DATA_W'($urandom_range(1, 255));
      end
      apply_regs();
      mf = model_fail();
      build_trace();
      pulse_start();
      foreach (exp_q[k]) begin
        if (k > 0) begin @(posedge clock); #1; end
        o = get_obs();
        n_checks++;
        if (o !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random_trace cycle %0d: got %h expected %h", k, o, exp_q[k]);
        end
      end
      n_checks++;
      if (pass !== (mf < 0) || fail_idx !== IW'((mf < 0) ? 0 : mf)) begin
        n_fail++;
        $display("FAIL random_result: pass=%b fail_idx=%0d, need %0b/%0d", pass, fail_idx, mf < 0, (mf < 0) ? 0 : mf);
      end
    end
  endtask

  initial begin
    for (int e = 0; e < DEPTH; e++) begin
      m_instr[e] = '0; m_hold[e] = 0; m_last[e] = 1'b0;
    end
    for (int i = 0; i < NREG; i++) begin
      m_exp[i] = '0; regs[i] = '0;
`ifdef EXP_MASK_EN
      m_vld[i] = 1'b0;
`else
      m_vld[i] = 1'b1;
`endif
    end
    test_reset();
    test_basic_pass();
    test_single_mismatch();
    test_multi_mismatch();
    test_start_while_busy();
    test_load_while_busy();
    test_load_with_start();
    test_no_last();
    test_reset_mid_run();
    test_mask();
    test_random_programs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
